// File: rtl/lowmem_pkg.sv
// Shared definitions for the two-port lowmem burst arbiter.
package lowmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/lowmem_arb_pick.sv
// Two-way winner select: fixed priority (p0 first) by default,
// round-robin when LOWMEM_ARB_RR_EN is defined.
module lowmem_arb_pick
  import lowmem_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       last,
  output logic       winner
);

`ifdef LOWMEM_ARB_RR_EN
  always_comb begin
    if (&pending) winner = ~last;
    else          winner = pending[P1] & ~pending[P0];
  end
`else
  logic unused_last;
  assign unused_last = last;
  assign winner = pending[P0] ? P0 : P1;
`endif

endmodule

// File: rtl/lowmem_arbiter.sv
// Two-port burst arbiter in front of the lowmem burst interface.
// Arbitration policy selected by LOWMEM_ARB_RR_EN (round-robin) or fixed.
module lowmem_arbiter
  import lowmem_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      p0_a,
  input  logic [31:0]      p0_d,
  input  logic             p0_we,
  input  logic             p0_rd,
  input  logic             p0_burst_en,
  input  logic [LEN_W-1:0] p0_burst_length,
  output logic [31:0]      p0_spo,
  output logic             p0_ready,
  output logic             p0_busy,
  input  logic [31:0]      p1_a,
  input  logic [31:0]      p1_d,
  input  logic             p1_we,
  input  logic             p1_rd,
  input  logic             p1_burst_en,
  input  logic [LEN_W-1:0] p1_burst_length,
  output logic [31:0]      p1_spo,
  output logic             p1_ready,
  output logic             p1_busy,
  output logic [31:0]      lowmem_a,
  output logic [31:0]      lowmem_d,
  output logic             lowmem_we,
  output logic             lowmem_rd,
  output logic             lowmem_burst_en,
  output logic [LEN_W-1:0] lowmem_burst_length,
  input  logic [31:0]      lowmem_spo,
  input  logic             lowmem_ready,
  output logic [1:0]       grant
);

  localparam int CW = LEN_W + 1;

  state_e                state_q, state_d;
  logic [1:0]            pend_q, we_q, ben_q;
  logic [1:0][31:0]      a_q;
  logic [1:0][LEN_W-1:0] len_q;
  logic [1:0]            grant_q, grant_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc, tgt;
  logic                  lm_we_q, lm_we_d, lm_rd_q, lm_rd_d;
  logic                  lm_ben_q, lm_ben_d;
  logic [31:0]           lm_a_q, lm_a_d;
  logic [LEN_W-1:0]      lm_len_q, lm_len_d;

  logic [1:0]            req, acc, eff, in_we, in_ben;
  logic [1:0][31:0]      in_a;
  logic [1:0][LEN_W-1:0] in_len;
  logic                  winner, done;
  logic                  sel_we, sel_ben;
  logic [31:0]           sel_a;
  logic [LEN_W-1:0]      sel_len;

  assign req    = {p1_we | p1_rd, p0_we | p0_rd};
  assign in_we  = {p1_we, p0_we};
  assign in_ben = {p1_burst_en, p0_burst_en};
  assign in_a   = {p1_a, p0_a};
  assign in_len = {p1_burst_length, p0_burst_length};

  assign acc = req & ~pend_q;
  assign eff = pend_q | acc;

  lowmem_arb_pick u_pick (
    .pending (eff),
    .last    (last_q),
    .winner  (winner)
  );

  // A request accepted in the idle cycle is bypassed straight to issue.
  assign sel_we  = pend_q[winner] ? we_q[winner]  : in_we[winner];
  assign sel_ben = pend_q[winner] ? ben_q[winner] : in_ben[winner];
  assign sel_a   = pend_q[winner] ? a_q[winner]   : in_a[winner];
  assign sel_len = pend_q[winner] ? len_q[winner] : in_len[winner];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      we_q   <= '0;
      ben_q  <= '0;
      a_q    <= '0;
      len_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          pend_q[i] <= 1'b1;
          we_q[i]   <= in_we[i];
          ben_q[i]  <= in_ben[i];
          a_q[i]    <= in_a[i];
          len_q[i]  <= in_len[i];
        end else if (done && grant_q[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign tgt = (lm_ben_q && (lm_len_q != '0)) ? {1'b0, lm_len_q}
                                              : CW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    lm_we_d  = 1'b0;
    lm_rd_d  = 1'b0;
    lm_ben_d = lm_ben_q;
    lm_a_d   = lm_a_q;
    lm_len_d = lm_len_q;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|eff) begin
          grant_d  = winner ? 2'b10 : 2'b01;
          last_d   = winner;
          cnt_d    = '0;
          lm_we_d  = sel_we;
          lm_rd_d  = ~sel_we;
          lm_ben_d = sel_ben;
          lm_a_d   = sel_a;
          lm_len_d = sel_len;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_XFER;
      S_XFER: begin
        if (lowmem_ready) begin
          if (cnt_inc == tgt) begin
            done    = 1'b1;
            grant_d = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= P1;
      cnt_q    <= '0;
      lm_we_q  <= 1'b0;
      lm_rd_q  <= 1'b0;
      lm_ben_q <= 1'b0;
      lm_a_q   <= '0;
      lm_len_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      lm_we_q  <= lm_we_d;
      lm_rd_q  <= lm_rd_d;
      lm_ben_q <= lm_ben_d;
      lm_a_q   <= lm_a_d;
      lm_len_q <= lm_len_d;
    end
  end

  assign grant               = grant_q;
  assign lowmem_a            = lm_a_q;
  assign lowmem_we           = lm_we_q;
  assign lowmem_rd           = lm_rd_q;
  assign lowmem_burst_en     = lm_ben_q;
  assign lowmem_burst_length = lm_len_q;
  assign lowmem_d = grant_q[P1] ? p1_d : (grant_q[P0] ? p0_d : '0);

  assign p0_spo   = lowmem_spo;
  assign p1_spo   = lowmem_spo;
  assign p0_busy  = pend_q[P0];
  assign p1_busy  = pend_q[P1];
  assign p0_ready = lowmem_ready & grant_q[P0] & (state_q == S_XFER);
  assign p1_ready = lowmem_ready & grant_q[P1] & (state_q == S_XFER);

endmodule

// File: tb/tb_lowmem_arbiter.sv
// Scoreboard bench for lowmem_arbiter with a bursty lowmem responder.
module tb_lowmem_arbiter;

  localparam int LEN_W = 8;

  logic             clk, rst;
  logic [31:0]      p0_a, p0_d, p1_a, p1_d;
  logic             p0_we, p0_rd, p1_we, p1_rd;
  logic             p0_burst_en, p1_burst_en;
  logic [LEN_W-1:0] p0_burst_length, p1_burst_length;
  logic [31:0]      p0_spo, p1_spo;
  logic             p0_ready, p1_ready, p0_busy, p1_busy;
  logic [31:0]      lowmem_a, lowmem_d, lowmem_spo;
  logic             lowmem_we, lowmem_rd, lowmem_burst_en, lowmem_ready;
  logic [LEN_W-1:0] lowmem_burst_length;
  logic [1:0]       grant;

  lowmem_arbiter #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .p0_a(p0_a), .p0_d(p0_d), .p0_we(p0_we), .p0_rd(p0_rd),
    .p0_burst_en(p0_burst_en), .p0_burst_length(p0_burst_length),
    .p0_spo(p0_spo), .p0_ready(p0_ready), .p0_busy(p0_busy),
    .p1_a(p1_a), .p1_d(p1_d), .p1_we(p1_we), .p1_rd(p1_rd),
    .p1_burst_en(p1_burst_en), .p1_burst_length(p1_burst_length),
    .p1_spo(p1_spo), .p1_ready(p1_ready), .p1_busy(p1_busy),
    .lowmem_a(lowmem_a), .lowmem_d(lowmem_d),
    .lowmem_we(lowmem_we), .lowmem_rd(lowmem_rd),
    .lowmem_burst_en(lowmem_burst_en),
    .lowmem_burst_length(lowmem_burst_length),
    .lowmem_spo(lowmem_spo), .lowmem_ready(lowmem_ready),
    .grant(grant)
  );

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    bit          ben;
    int          len;
    int          n;
    bit          b2b;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_rdy = 0;
  int   rdy_cnt = 0;
  bit   active = 0;
  bit   done_chk = 0;
  int   poke_req = 0;
  int   poke_ack = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input bit p, input bit we, input logic [31:0] a,
                      input bit ben, input int len, input bit b2b);
    exp_t e;
    e.port = p; e.we = we; e.addr = a; e.ben = ben; e.len = len;
    e.n = (ben && len != 0) ? len : 1;
    e.b2b = b2b;
    sb.push_back(e);
  endtask

  task automatic set_req(input bit p, input bit we, input logic [31:0] a,
                         input bit ben, input int len);
    if (!p) begin
      p0_we = we; p0_rd = !we; p0_a = a;
      p0_burst_en = ben; p0_burst_length = LEN_W'(len);
    end else begin
      p1_we = we; p1_rd = !we; p1_a = a;
      p1_burst_en = ben; p1_burst_length = LEN_W'(len);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    p0_we = 0; p0_rd = 0; p1_we = 0; p1_rd = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb.size() == 0 && !active && !done_chk) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    p0_d = 0; p1_d = 0;
    forever begin
      @(posedge clk); #1;
      p0_d = $urandom; p1_d = $urandom;
    end
  end

  // Lowmem responder: n ready pulses with random gaps after each issue.
  initial begin
    int n, k;
    logic [31:0] base;
    lowmem_ready = 0; lowmem_spo = 0;
    forever begin
      @(negedge clk);
      if (!rst && (lowmem_rd || lowmem_we)) begin
        n = (lowmem_burst_en && lowmem_burst_length != 0)
            ? int'(lowmem_burst_length) : 1;
        base = lowmem_a;
        k = 0;
        while (k < n) begin
          @(posedge clk); #1;
          if (rst) begin
            lowmem_ready = 0;
            break;
          end
          if ($urandom_range(0, 4) == 0) lowmem_ready = 0;
          else begin
            lowmem_ready = 1; lowmem_spo = base + k; k++;
          end
        end
        @(posedge clk); #1;
        lowmem_ready = 0;
      end else if (poke_req != poke_ack) begin
        @(posedge clk); #1; lowmem_ready = 1;
        @(posedge clk); #1; lowmem_ready = 0;
        poke_ack++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        active = 0; done_chk = 0;
      end else begin
        if (done_chk) begin
          chk("grant_clr", 32'(grant), 0);
          chk("busy_clr", 32'(cur.port ? p1_busy : p0_busy), 0);
          done_chk = 0;
        end
        if (lowmem_rd || lowmem_we) begin
          if (sb.size() == 0) begin
            chk("unexp_issue", 32'({lowmem_we, lowmem_rd}), 0);
          end else begin
            cur = sb.pop_front();
            chk("grant", 32'(grant), cur.port ? 2 : 1);
            chk("we", 32'(lowmem_we), 32'(cur.we));
            chk("rd", 32'(lowmem_rd), 32'(!cur.we));
            chk("addr", lowmem_a, cur.addr);
            chk("ben", 32'(lowmem_burst_en), 32'(cur.ben));
            chk("blen", 32'(lowmem_burst_length), 32'(cur.len));
            chk("busy", 32'(cur.port ? p1_busy : p0_busy), 1);
            if (cur.b2b) chk("b2b_gap", 32'(cyc - last_rdy), 2);
            active = 1; rdy_cnt = 0;
          end
        end
        if (lowmem_ready) begin
          if (!active) begin
            chk("idle_rdy", 32'({p1_ready, p0_ready}), 0);
          end else begin
            chk("rdy_gate", 32'({p1_ready, p0_ready}), cur.port ? 2 : 1);
            if (cur.we)
              chk("wdata", lowmem_d, cur.port ? p1_d : p0_d);
            else
              chk("rdata", cur.port ? p1_spo : p0_spo,
                  cur.addr + 32'(rdy_cnt));
            rdy_cnt++;
            last_rdy = cyc;
            if (rdy_cnt == cur.n) begin
              active = 0; done_chk = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    rst = 1;
    p0_a = 0; p0_we = 0; p0_rd = 0; p0_burst_en = 0; p0_burst_length = 0;
    p1_a = 0; p1_we = 0; p1_rd = 0; p1_burst_en = 0; p1_burst_length = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_lm_rdwe", 32'({lowmem_rd, lowmem_we}), 0);
    chk("rst_lm_a", lowmem_a, 0);
    chk("rst_lm_d", lowmem_d, 0);
    chk("rst_busy", 32'({p1_busy, p0_busy}), 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    set_req(0, 0, 32'h1000, 1, 32);
    push(0, 0, 32'h1000, 1, 32, 0);
    step();
    wait_idle(500);

    set_req(0, 0, 32'h1200, 1, 0);
    push(0, 0, 32'h1200, 1, 0, 0);
    step();
    wait_idle(100);

    set_req(1, 0, 32'h1100, 0, 5);
    push(1, 0, 32'h1100, 0, 5, 0);
    step();
    wait_idle(100);

    set_req(0, 1, 32'h2000, 1, 32);
    set_req(1, 0, 32'h3000, 1, 4);
`ifdef LOWMEM_ARB_RR_EN
    push(0, 1, 32'h2000, 1, 32, 0);
    push(1, 0, 32'h3000, 1, 4, 1);
    push(0, 0, 32'h4000, 1, 3, 1);
`else
    push(0, 1, 32'h2000, 1, 32, 0);
    push(0, 0, 32'h4000, 1, 3, 1);
    push(1, 0, 32'h3000, 1, 4, 1);
`endif
    step();
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (done_chk) begin
        ok = 1;
        break;
      end
    end
    chk("p0_end_timeout", 32'(ok), 1);
    #1;
    set_req(0, 0, 32'h4000, 1, 3);
    step();
    wait_idle(500);

    set_req(0, 0, 32'h5000, 1, 4);
    push(0, 0, 32'h5000, 1, 4, 0);
    step();
    set_req(0, 0, 32'h6000, 1, 4);
    @(negedge clk);
    chk("busy_set", 32'(p0_busy), 1);
    step();
    wait_idle(200);

    poke_req++;
    repeat (5) @(posedge clk);
    #1;

    set_req(0, 0, 32'h7000, 1, 32);
    push(0, 0, 32'h7000, 1, 32, 0);
    step();
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (active && rdy_cnt >= 10) begin
        ok = 1;
        break;
      end
    end
    chk("rdy10_timeout", 32'(ok), 1);
    #1;
    rst = 1;
    #1;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_rdwe", 32'({lowmem_rd, lowmem_we}), 0);
    chk("mid_rst_a", lowmem_a, 0);
    chk("mid_rst_d", lowmem_d, 0);
    chk("mid_rst_blen", 32'(lowmem_burst_length), 0);
    chk("mid_rst_busy", 32'({p1_busy, p0_busy}), 0);
    chk("mid_rst_rdy", 32'({p1_ready, p0_ready}), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 0, 32'h8000, 1, 2);
    push(0, 0, 32'h8000, 1, 2, 0);
    step();
    wait_idle(200);

    set_req(1, 0, 32'h9000, 1, 255);
    push(1, 0, 32'h9000, 1, 255, 0);
    step();
    wait_idle(2000);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lowmem_arbiter.md
LOWMEM_ARBITER -- requirements
Module: lowmem_arbiter

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of burst length fields.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have ports p0_a/p1_a, input, 32, burst start address, sampled with request strobe.
REQ-005 SHALL have ports p0_d/p1_d, input, 32, write data word, forwarded while that port owns the bus.
REQ-006 SHALL have ports p0_we/p1_we and p0_rd/p1_rd, input, 1, one-cycle request strobes.
REQ-007 SHALL have ports p0_burst_en/p1_burst_en, input, 1, burst mode; 0 means single word.
REQ-008 SHALL have ports p0_burst_length/p1_burst_length, input, LEN_W, words per burst.
REQ-009 SHALL have ports p0_spo/p1_spo, output, 32, read data, equal to lowmem_spo.
REQ-010 SHALL have ports p0_ready/p1_ready, output, 1, per-word ready, lowmem_ready gated by grant.
REQ-011 SHALL have ports p0_busy/p1_busy, output, 1, request pending or in progress on that port.
REQ-012 SHALL have ports lowmem_a/lowmem_d, output, 32; lowmem_we/lowmem_rd/lowmem_burst_en, output, 1; lowmem_burst_length, output, LEN_W; lowmem_spo, input, 32; lowmem_ready, input, 1: downstream burst interface.
REQ-013 SHALL have port grant, output, 2, one-hot current bus owner, 0 when idle.

Function
REQ-014 SHALL latch each strobe into a per-port pending slot (a, we/rd, burst_en, length); strobe while pN_busy=1 SHALL be ignored.
REQ-015 SHALL implement states IDLE, ISSUE, XFER.
REQ-016 IDLE: if any slot pending, select winner, set grant, go ISSUE; else stay.
REQ-017 ISSUE: lowmem_rd or lowmem_we high exactly one cycle with registered lowmem_a/burst_en/burst_length from the winner slot; go XFER.
REQ-018 XFER: count lowmem_ready pulses; on pulse number N (N = length, or 1 if burst_en=0 or length=0) clear slot and grant, go IDLE next edge.
REQ-019 lowmem_d SHALL mux pN_d of granted port; lowmem_ready while idle SHALL be ignored.
REQ-020 pN_ready SHALL be zero for the non-granted port and outside XFER.
REQ-021 Simultaneous strobes on both ports in the same cycle SHALL both be latched.
REQ-022 Back-to-back: second pending port SHALL see its ISSUE 2 cycles after first burst's last ready.
REQ-023 Counter SHALL be LEN_W+1 bits; no wrap for length 2^LEN_W-1.

Reset
REQ-024 rst SHALL immediately set state IDLE, grant 0, pending slots cleared, counter 0, lowmem_we/rd 0, lowmem_a/d/burst_length 0, busy 0; mid-burst transfers SHALL be abandoned.

Configuration
REQ-025 With LOWMEM_ARB_RR_EN defined: round-robin, tie goes to port not served last (p0 after reset).
REQ-026 Without LOWMEM_ARB_RR_EN: fixed priority, p0 always wins ties.

Structure
REQ-027 State encoding and port-index constants SHALL live in shared package lowmem_pkg.
REQ-028 Winner selection SHALL be sub-module lowmem_arb_pick (pending[1:0], last -> winner).

Verification
REQ-029 p0_rd, a=0x1000, len 32 -> one lowmem_rd pulse, lowmem_a=0x1000, 32 p0_ready pulses, grant back to 0.
REQ-030 p0_we and p1_rd same cycle, RR -> p0 served first, p1 issued 2 cycles after p0's 32nd ready.
REQ-031 Same as 030 without macro, p0 re-requests during p0 burst end -> p0 wins again.
REQ-032 p1_rd burst_en=0 -> single ready pulse completes transfer.
REQ-033 rst asserted after 10 of 32 readies -> outputs zero same cycle, later p0 request issued normally.
REQ-034 second p0_rd while p0_busy=1 -> ignored, only one lowmem_rd.
